blur_frame_ctrl: RTL

//  Frame sequencer for the gaussian_blur streaming core. On start it clears the core, reads one
//  IMG_W x IMG_H frame from a source pixel RAM (raster order), and streams it into the core.
//  It captures every core output into a destination RAM, then signals done, or err on a

---
 rtl/blur_frame_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/blur_frame_ctrl.sv
// Frame sequencer for gaussian_blur: clears the core, streams one raster frame from the
// source RAM into it, captures every core output into the destination RAM, then reports done/err.
module blur_frame_ctrl #(
  parameter int unsigned IMG_W   = 256,
  parameter int unsigned IMG_H   = 256,
  parameter int unsigned NPIX    = IMG_W * IMG_H,
  parameter int unsigned OUT_PIX = IMG_W * IMG_H,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              core_rst,
  output logic [7:0]        core_pixel,
  output logic              core_valid,
  input  logic [7:0]        core_out,
  input  logic              core_out_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  // out_cnt gets one extra bit so it can hold OUT_PIX itself when OUT_PIX == 2**ADDR_W
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMR_W = 16;

  localparam logic [ADDR_W-1:0] LAST_RD   = ADDR_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  OUT_LIMIT = CNT_W'(OUT_PIX);
  localparam logic [TMR_W-1:0]  TMO_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              core_rst_q, core_rst_d;
  logic              core_valid_q, core_valid_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  // Next-state, counters and output values
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    err_d        = err_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    core_rst_d   = 1'b0;
    core_valid_d = rd_en_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_idx_d     = rd_idx_q;
    out_cnt_d    = out_cnt_q;
    timer_d      = timer_q;

    if ((state_q == S_FEED || state_q == S_DRAIN) && core_out_valid) begin
      if (out_cnt_q < OUT_LIMIT) begin
        wr_en_d   = 1'b1;
        wr_addr_d = out_cnt_q[ADDR_W-1:0];
        wr_data_d = core_out;
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d      = 1'b0;
          core_rst_d = 1'b1;
          rd_idx_d   = '0;
          out_cnt_d  = '0;
          timer_d    = '0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        rd_idx_d  = '0;
        out_cnt_d = '0;
        timer_d   = '0;
        state_d   = S_FEED;
      end
      S_FEED: begin
        if (!hold) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_idx_q;
          if (rd_idx_q == LAST_RD) begin
            state_d = S_DRAIN;
          end else begin
            rd_idx_d = rd_idx_q + ADDR_W'(1);
          end
        end
      end
      S_DRAIN: begin
        timer_d = timer_q + TMR_W'(1);
        if (out_cnt_q == OUT_LIMIT) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (timer_q == TMO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything computed above and leaves err and the RAM buses untouched
    if (abort) begin
      state_d      = S_IDLE;
      done_d       = 1'b0;
      err_d        = err_q;
      rd_en_d      = 1'b0;
      rd_addr_d    = rd_addr_q;
      core_rst_d   = 1'b0;
      core_valid_d = 1'b0;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      out_cnt_d    = out_cnt_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      core_rst_q   <= 1'b1;
      core_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_idx_q     <= '0;
      out_cnt_q    <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      core_rst_q   <= core_rst_d;
      core_valid_q <= core_valid_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_idx_q     <= rd_idx_d;
      out_cnt_q    <= out_cnt_d;
      timer_q      <= timer_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign core_rst   = core_rst_q;
  assign core_valid = core_valid_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

  // The source RAM output register is the pixel stage, so the pixel is forwarded in the
  // cycle its read returns; gating keeps it at zero whenever no pixel is being presented.
  assign core_pixel = core_valid_q ? rd_data : 8'h00;

endmodule
